// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
// Contents: state encoding, default operand width, iteration counter width helper.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Counter must hold WIDTH-1, the index of the last iteration.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result interface of the sequential divider
// master: start, signed_op, dividend, divisor out; busy, done, quotient, remainder, div_by_zero in.
// slave:  mirror of master (the divider side).
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sub_row.sv
// rtl/div_sub_row.sv - N-bit ripple subtractor, diff = a - b, borrow out
// Ports: a, b (minuend, subtrahend), diff (difference), borrow (1 when a < b).
module div_sub_row #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic bw;

    always_comb begin
        bw   = 1'b0;
        diff = '0;
        for (int i = 0; i < N; i++) begin
            diff[i] = a[i] ^ b[i] ^ bw;
            bw      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        borrow = bw;
    end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider (DIV/DIVU), one quotient bit per cycle
// Ports: clk, rst_n (async, active low); bus (seq_divider_if.slave): start/signed_op/
//        dividend/divisor in, busy/done/quotient/remainder/div_by_zero out.
// Macro DIV_SIGNED_EN: adds signed operation (PREP/FIX states); undefined = unsigned only.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] quo;      // dividend, then quotient bits shifted in from the LSB
    logic [WIDTH-1:0] rem;      // partial remainder
    logic [WIDTH-1:0] dmag;     // divisor (magnitude once PREP has run)
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] cnt;
    logic             dbz;
    logic             last;
    logic             busy_c;
    logic             done_c;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

`ifdef DIV_SIGNED_EN
    logic op_sgn;
    logic sign_q;
    logic sign_r;
`else
    logic zero_pend;
    wire  unused_signed_op = bus.signed_op;
`endif

    assign last    = (cnt == CNT_LAST);
    assign shifted = {rem, quo[WIDTH-1]};

    div_sub_row #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dmag}),
        .diff   (trial),
        .borrow (borrow)
    );

    // On borrow the shifted value is below the divisor, so it fits in WIDTH bits;
    // without borrow the difference is below the divisor as well.
    assign rem_step = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_step = {quo[WIDTH-2:0], ~borrow};
    wire   unused_trial_msb = trial[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_c    = (state != S_IDLE);
        done_c    = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (bus.start) begin
`ifdef DIV_SIGNED_EN
                    state_nxt = S_PREP;
`else
                    state_nxt = S_ITER;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            S_PREP: state_nxt = (dmag == '0) ? S_DONE : S_ITER;
            S_ITER: if (last) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
`else
            S_ITER: if (zero_pend || last) state_nxt = S_DONE;
`endif
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo    <= '0;
            rem    <= '0;
            dmag   <= '0;
            q_out  <= '0;
            r_out  <= '0;
            cnt    <= '0;
            dbz    <= 1'b0;
`ifdef DIV_SIGNED_EN
            op_sgn <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
`else
            zero_pend <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        quo  <= bus.dividend;
                        dmag <= bus.divisor;
                        rem  <= '0;
                        cnt  <= '0;
                        dbz  <= 1'b0;
`ifdef DIV_SIGNED_EN
                        op_sgn <= bus.signed_op;
`else
                        zero_pend <= (bus.divisor == '0);
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                S_PREP: begin
                    if (dmag == '0) begin
                        q_out <= '1;
                        r_out <= quo;
                        dbz   <= 1'b1;
                    end else begin
                        if (op_sgn && quo[WIDTH-1])  quo  <= -quo;
                        if (op_sgn && dmag[WIDTH-1]) dmag <= -dmag;
                        sign_q <= op_sgn & (quo[WIDTH-1] ^ dmag[WIDTH-1]);
                        sign_r <= op_sgn & quo[WIDTH-1];
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                S_ITER: begin
                    rem <= rem_step;
                    quo <= quo_step;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    // MIN / -1: magnitude quotient is MIN and sign_q is 0, so MIN passes through.
                    q_out <= sign_q ? -quo : quo;
                    r_out <= sign_r ? -rem : rem;
                end
`else
                S_ITER: begin
                    if (zero_pend) begin
                        q_out <= '1;
                        r_out <= quo;
                        dbz   <= 1'b1;
                    end else begin
                        rem <= rem_step;
                        quo <= quo_step;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            q_out <= quo_step;
                            r_out <= rem_step;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.quotient    = q_out;
    assign bus.remainder   = r_out;
    assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 16;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   done_cnt;
    int   lat;
    int   d0;

    seq_divider_if #(.WIDTH(16)) bus ();

    seq_divider #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the divider is idle; returns 1 time unit after the sampling edge.
    task automatic start_op(input logic sgn, input logic [15:0] a, input logic [15:0] b);
        bus.start     = 1'b1;
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Counts cycles after the sampling edge until done is seen; -1 on timeout.
    task automatic wait_done(output int l);
        l = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz, input int elat);
        int l;
        @(negedge clk);
        start_op(sgn, a, b);
        wait_done(l);
        check({tag, " latency"}, l, elat);
        check({tag, " quotient"}, {16'h0, bus.quotient}, {16'h0, eq});
        check({tag, " remainder"}, {16'h0, bus.remainder}, {16'h0, er});
        check({tag, " div_by_zero"}, {31'h0, bus.div_by_zero}, {31'h0, edz});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0; done_cnt = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.signed_op = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst busy", {31'h0, bus.busy}, 0);
        check("rst done", {31'h0, bus.done}, 0);
        check("rst quotient", {16'h0, bus.quotient}, 0);
        check("rst remainder", {16'h0, bus.remainder}, 0);
        check("rst div_by_zero", {31'h0, bus.div_by_zero}, 0);

        do_op("u100/7", 1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT);
        @(negedge clk);
        check("done pulse width", {31'h0, bus.done}, 0);
        check("busy after done", {31'h0, bus.busy}, 0);

`ifdef DIV_SIGNED_EN
        do_op("s-7/2", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, LAT);
        do_op("s7/-2", 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, LAT);
`else
        do_op("s-7/2", 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, LAT);
        do_op("s7/-2", 1'b1, 16'h0007, 16'hFFFE, 16'h0000, 16'h0007, 1'b0, LAT);
`endif

        do_op("div0", 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1);
        @(negedge clk);
        start_op(1'b0, 16'd100, 16'd7);
        @(negedge clk);
        check("div0 flag cleared on start", {31'h0, bus.div_by_zero}, 0);
        wait_done(lat);
        check("after div0 quotient", {16'h0, bus.quotient}, 14);
        check("after div0 remainder", {16'h0, bus.remainder}, 2);

`ifdef DIV_SIGNED_EN
        do_op("min/-1", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, LAT);
`else
        do_op("min/-1", 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, LAT);
`endif
        do_op("uFFFF/1", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, LAT);

        // second start mid-operation must be ignored
        @(negedge clk);
        d0 = done_cnt;
        start_op(1'b0, 16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        check("ignored start quotient", {16'h0, bus.quotient}, 333);
        check("ignored start remainder", {16'h0, bus.remainder}, 1);
        repeat (25) @(negedge clk);
        check("ignored start done count", done_cnt - d0, 1);

        // start held from the done cycle: ignored in DONE, accepted in the next IDLE
        do_op("u200/10", 1'b0, 16'd200, 16'd10, 16'd20, 16'd0, 1'b0, LAT);
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 16'd201; bus.divisor = 16'd10;
        @(posedge clk);
        @(negedge clk);
        check("start in done ignored", {31'h0, bus.busy}, 0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        check("b2b latency", lat, LAT);
        check("b2b quotient", {16'h0, bus.quotient}, 20);
        check("b2b remainder", {16'h0, bus.remainder}, 1);

        // asynchronous reset in the middle of iteration
        @(negedge clk);
        d0 = done_cnt;
        start_op(1'b0, 16'd1000, 16'd3);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", {31'h0, bus.busy}, 0);
        check("midrst done", {31'h0, bus.done}, 0);
        check("midrst quotient", {16'h0, bus.quotient}, 0);
        check("midrst remainder", {16'h0, bus.remainder}, 0);
        check("midrst div_by_zero", {31'h0, bus.div_by_zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst no done", done_cnt - d0, 0);
        do_op("u50/5", 1'b0, 16'd50, 16'd5, 16'd10, 16'd0, 1'b0, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
